fpadd_share_ctrl: RTL



---
 rtl/fpadd_pkg.sv | 20 ++
 rtl/floatingptoper.sv | 50 +++++
 rtl/fpadd_share_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fpadd_pkg.sv
// Shared widths, operand layout and FSM encoding for the shared FP add/sub sequencer.
package fpadd_pkg;

  localparam int unsigned MANT_W = 11;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned OPND_W = 1 + EXP_W + MANT_W;
  localparam int unsigned CNT_W  = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic              sgn;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } opnd_t;

endpackage

// File: rtl/floatingptoper.sv
// Unclocked sign-magnitude add/subtract: aligns the smaller-exponent operand, result keeps
// the larger exponent and an unnormalised mantissa with carry bit.
module floatingptoper
  import fpadd_pkg::*;
(
  input  logic              sgn1,
  input  logic [EXP_W-1:0]  exp1,
  input  logic [MANT_W-1:0] inp1,
  input  logic              sgn2,
  input  logic [EXP_W-1:0]  exp2,
  input  logic [MANT_W-1:0] inp2,
  input  logic              operatin,
  output logic              res_sgn,
  output logic [EXP_W:0]    res_exp,
  output logic [MANT_W:0]   res_mant
);

  logic              a_big;
  logic              s_big;
  logic              s_small;
  logic              sgn2_eff;
  logic [EXP_W-1:0]  e_big;
  logic [EXP_W-1:0]  ediff;
  logic [MANT_W-1:0] m_big;
  logic [MANT_W-1:0] m_small;

  // Operand A is treated as the larger one on equal exponents.
  always_comb begin
    sgn2_eff = (operatin == OP_SUB) ? ~sgn2 : sgn2;
    a_big    = (exp1 >= exp2);
    e_big    = a_big ? exp1 : exp2;
    ediff    = a_big ? (exp1 - exp2) : (exp2 - exp1);
    s_big    = a_big ? sgn1 : sgn2_eff;
    s_small  = a_big ? sgn2_eff : sgn1;
    m_big    = a_big ? inp1 : inp2;
    m_small  = (a_big ? inp2 : inp1) >> ediff;
    res_exp  = {1'b0, e_big};
    if (s_big == s_small) begin
      res_mant = {1'b0, m_big} + {1'b0, m_small};
      res_sgn  = s_big;
    end else if (m_big >= m_small) begin
      res_mant = {1'b0, m_big} - {1'b0, m_small};
      res_sgn  = s_big;
    end else begin
      res_mant = {1'b0, m_small} - {1'b0, m_big};
      res_sgn  = s_small;
    end
  end

endmodule

// File: rtl/fpadd_share_ctrl.sv
// Round-robin shares one combinational floatingptoper between two requesters; operands are
// held for EXEC_CYCLES settle cycles, then the result is registered until accepted.
module fpadd_share_ctrl
  import fpadd_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic              req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  input  logic              req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_sgn,
  output logic [EXP_W:0]    rsp_exp,
  output logic [MANT_W:0]   rsp_mant,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  opnd_t             opa;
  opnd_t             opb;
  logic              op_q;
  logic              win_valid;
  logic              grant;
  logic              res_sgn;
  logic [EXP_W:0]    res_exp;
  logic [MANT_W:0]   res_mant;

  // Arbitration is only live in IDLE and out of reset; a tie goes to the requester not served last.
  always_comb begin
    win_valid = 1'b0;
    grant     = 1'b0;
    if (state == IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
        win_valid = 1'b1;
        grant     = ~last_grant;
      end else if (req0_valid) begin
        win_valid = 1'b1;
      end else if (req1_valid) begin
        win_valid = 1'b1;
        grant     = 1'b1;
      end
    end
  end

  assign req0_ready = win_valid & ~grant;
  assign req1_ready = win_valid & grant;

  floatingptoper u_fpop (
    .sgn1     (opa.sgn),
    .exp1     (opa.exp),
    .inp1     (opa.mant),
    .sgn2     (opb.sgn),
    .exp2     (opb.exp),
    .inp2     (opb.mant),
    .operatin (op_q),
    .res_sgn  (res_sgn),
    .res_exp  (res_exp),
    .res_mant (res_mant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      opa        <= '0;
      opb        <= '0;
      op_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sgn    <= 1'b0;
      rsp_exp    <= '0;
      rsp_mant   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            opa        <= grant ? req1_a : req0_a;
            opb        <= grant ? req1_b : req0_b;
            op_q       <= grant ? req1_op : req0_op;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_sgn   <= res_sgn;
            rsp_exp   <= res_exp;
            rsp_mant  <= res_mant;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
